// File: rtl/mux_key_pkg.sv
// Shared constants and helpers for the programmable key lookup table.
package mux_key_pkg;

    // Response status encoding carried on resp_hit
    localparam logic ST_HIT  = 1'b1;
    localparam logic ST_MISS = 1'b0;

    // Index width that never collapses to zero bits for tiny tables
    function automatic int unsigned idx_width(input int unsigned n);
        if (n <= 2) begin
            return 1;
        end
        return $clog2(n);
    endfunction

endpackage

// File: rtl/mux_key_prio_enc.sv
// Priority encoder: match vector -> any-match flag and lowest matching index.
module mux_key_prio_enc #(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = 2
) (
    input  logic [N-1:0]  match,
    output logic          any_c,
    output logic [IW-1:0] idx_c
);

    // Scan from the top down so the lowest set bit is the last assignment
    always_comb begin
        any_c = |match;
        idx_c = '0;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (match[i]) begin
                idx_c = IW'(i);
            end
        end
    end

endmodule

// File: rtl/mux_key_table.sv
// Programmable registered key->data lookup table with valid/ready request
// and back-pressurable single-register response.
// Optional macro MUX_KEY_TABLE_BYPASS_EN: a lookup accepted together with a
// write/clr sees the post-edge table (write forwarding, clr forces miss).
module mux_key_table
    import mux_key_pkg::*;
#(
    parameter int unsigned NR_KEY      = 4,
    parameter int unsigned KEY_LEN     = 8,
    parameter int unsigned DATA_LEN    = 32,
    parameter int unsigned HAS_DEFAULT = 0,
    parameter int unsigned IDX_W       = idx_width(NR_KEY)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clr,
    input  logic                wr_en,
    input  logic [IDX_W-1:0]    wr_idx,
    input  logic [KEY_LEN-1:0]  wr_key,
    input  logic [DATA_LEN-1:0] wr_data,
    input  logic [DATA_LEN-1:0] default_out,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [KEY_LEN-1:0]  req_key,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [DATA_LEN-1:0] resp_data,
    output logic                resp_hit,
    output logic [IDX_W-1:0]    resp_idx
);

    // Table storage
    logic [NR_KEY-1:0]   valid_q, valid_d;
    logic [KEY_LEN-1:0]  key_q  [NR_KEY];
    logic [KEY_LEN-1:0]  key_d  [NR_KEY];
    logic [DATA_LEN-1:0] data_q [NR_KEY];
    logic [DATA_LEN-1:0] data_d [NR_KEY];

    // Table view seen by the lookup
    logic [NR_KEY-1:0]   lk_valid;
    logic [KEY_LEN-1:0]  lk_key  [NR_KEY];
    logic [DATA_LEN-1:0] lk_data [NR_KEY];

    logic [NR_KEY-1:0]   match_c;
    logic                hit_c;
    logic [IDX_W-1:0]    hit_idx_c;
    logic                wr_in_range_c;
    logic                accept_c;

    // Response register
    logic                resp_valid_q, resp_valid_d;
    logic [DATA_LEN-1:0] resp_data_q,  resp_data_d;
    logic                resp_hit_q,   resp_hit_d;
    logic [IDX_W-1:0]    resp_idx_q,   resp_idx_d;

    assign wr_in_range_c = (32'(wr_idx) < NR_KEY);
    assign req_ready     = !resp_valid_q || resp_ready;
    assign accept_c      = req_valid && req_ready;

    // Next table contents: write first, clr overrides the written valid bit
    always_comb begin
        valid_d = valid_q;
        key_d   = key_q;
        data_d  = data_q;
        if (wr_en && wr_in_range_c) begin
            valid_d[wr_idx] = 1'b1;
            key_d[wr_idx]   = wr_key;
            data_d[wr_idx]  = wr_data;
        end
        if (clr) begin
            valid_d = '0;
        end
    end

    // Select pre-edge or post-edge table for the lookup
    always_comb begin
`ifdef MUX_KEY_TABLE_BYPASS_EN
        lk_valid = valid_d;
        lk_key   = key_d;
        lk_data  = data_d;
`else
        lk_valid = valid_q;
        lk_key   = key_q;
        lk_data  = data_q;
`endif
    end

    // Per-entry key compare
    always_comb begin
        match_c = '0;
        for (int i = 0; i < int'(NR_KEY); i++) begin
            match_c[i] = lk_valid[i] && (lk_key[i] == req_key);
        end
    end

    mux_key_prio_enc #(
        .N  (NR_KEY),
        .IW (IDX_W)
    ) u_prio_enc (
        .match (match_c),
        .any_c (hit_c),
        .idx_c (hit_idx_c)
    );

    // Response register next state: load on accept, hold under back-pressure
    always_comb begin
        resp_valid_d = resp_valid_q;
        resp_data_d  = resp_data_q;
        resp_hit_d   = resp_hit_q;
        resp_idx_d   = resp_idx_q;
        if (accept_c) begin
            resp_valid_d = 1'b1;
            if (hit_c) begin
                resp_hit_d  = ST_HIT;
                resp_idx_d  = hit_idx_c;
                resp_data_d = lk_data[hit_idx_c];
            end else begin
                resp_hit_d  = ST_MISS;
                resp_idx_d  = '0;
                resp_data_d = (HAS_DEFAULT != 0) ? default_out : '0;
            end
        end else if (resp_ready) begin
            resp_valid_d = 1'b0;
        end
    end

    // Valid bits and response register, async reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q      <= '0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            resp_hit_q   <= 1'b0;
            resp_idx_q   <= '0;
        end else begin
            valid_q      <= valid_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            resp_hit_q   <= resp_hit_d;
            resp_idx_q   <= resp_idx_d;
        end
    end

    // Entry key/data payload, gated by valid bits so no reset needed
    always_ff @(posedge clk) begin
        key_q  <= key_d;
        data_q <= data_d;
    end

    assign resp_valid = resp_valid_q;
    assign resp_data  = resp_data_q;
    assign resp_hit   = resp_hit_q;
    assign resp_idx   = resp_idx_q;

endmodule

// File: tb/tb_mux_key_table.sv
// Randomized self-checking bench for mux_key_table against a table model.
// Two instances share stimulus: HAS_DEFAULT=0 and HAS_DEFAULT=1.
module tb_mux_key_table;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clr, wr_en, req_valid, resp_ready;
    logic [1:0]  wr_idx;
    logic [7:0]  wr_key, req_key;
    logic [31:0] wr_data, default_out;

    logic        req_ready0, resp_valid0, resp_hit0;
    logic [31:0] resp_data0;
    logic [1:0]  resp_idx0;
    logic        req_ready1, resp_valid1, resp_hit1;
    logic [31:0] resp_data1;
    logic [1:0]  resp_idx1;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    bit          m_valid [4];
    logic [7:0]  m_key   [4];
    logic [31:0] m_data  [4];
    bit          e_valid;
    bit          e_hit;
    int          e_idx;
    logic [31:0] e_data0, e_data1;

    always #5 clk = ~clk;

    mux_key_table #(.NR_KEY(4), .KEY_LEN(8), .DATA_LEN(32), .HAS_DEFAULT(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .wr_en(wr_en), .wr_idx(wr_idx),
        .wr_key(wr_key), .wr_data(wr_data), .default_out(default_out),
        .req_valid(req_valid), .req_ready(req_ready0), .req_key(req_key),
        .resp_valid(resp_valid0), .resp_ready(resp_ready), .resp_data(resp_data0),
        .resp_hit(resp_hit0), .resp_idx(resp_idx0)
    );

    mux_key_table #(.NR_KEY(4), .KEY_LEN(8), .DATA_LEN(32), .HAS_DEFAULT(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .wr_en(wr_en), .wr_idx(wr_idx),
        .wr_key(wr_key), .wr_data(wr_data), .default_out(default_out),
        .req_valid(req_valid), .req_ready(req_ready1), .req_key(req_key),
        .resp_valid(resp_valid1), .resp_ready(resp_ready), .resp_data(resp_data1),
        .resp_hit(resp_hit1), .resp_idx(resp_idx1)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        clr = 0; wr_en = 0; req_valid = 0; resp_ready = 1;
        wr_idx = 0; wr_key = 0; wr_data = 0; req_key = 0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_valid[i] = 0;
        e_valid = 0; e_hit = 0; e_idx = 0; e_data0 = 0; e_data1 = 0;
    endtask

    // Lookup by first-match-lowest-index over the table the request sees
    task automatic model_lookup();
        bit          v [4];
        logic [7:0]  k [4];
        logic [31:0] d [4];
        for (int i = 0; i < 4; i++) begin
            v[i] = m_valid[i]; k[i] = m_key[i]; d[i] = m_data[i];
        end
`ifdef MUX_KEY_TABLE_BYPASS_EN
        if (wr_en) begin
            v[wr_idx] = 1; k[wr_idx] = wr_key; d[wr_idx] = wr_data;
        end
        if (clr) for (int i = 0; i < 4; i++) v[i] = 0;
`endif
        e_valid = 1; e_hit = 0; e_idx = 0; e_data0 = 0; e_data1 = default_out;
        for (int i = 0; i < 4; i++) begin
            if (!e_hit && v[i] && k[i] == req_key) begin
                e_hit = 1; e_idx = i; e_data0 = d[i]; e_data1 = d[i];
            end
        end
    endtask

    // One clock: check outputs mid-cycle, advance model, cross the edge
    task automatic step();
        bit acc;
        @(negedge clk);
        chk("req_ready0", 64'(req_ready0), 64'(!e_valid || resp_ready));
        chk("req_ready1", 64'(req_ready1), 64'(!e_valid || resp_ready));
        chk("resp_valid0", 64'(resp_valid0), 64'(e_valid));
        chk("resp_valid1", 64'(resp_valid1), 64'(e_valid));
        if (e_valid) begin
            chk("resp_hit", 64'(resp_hit0), 64'(e_hit));
            chk("resp_idx", 64'(resp_idx0), 64'(e_idx));
            chk("resp_data0", 64'(resp_data0), 64'(e_data0));
            chk("resp_data1", 64'(resp_data1), 64'(e_data1));
            chk("resp_hit1", 64'(resp_hit1), 64'(e_hit));
        end
        acc = req_valid && (!e_valid || resp_ready);
        if (acc) model_lookup();
        else if (resp_ready) e_valid = 0;
        if (wr_en) begin
            m_valid[wr_idx] = 1; m_key[wr_idx] = wr_key; m_data[wr_idx] = wr_data;
        end
        if (clr) for (int i = 0; i < 4; i++) m_valid[i] = 0;
        @(posedge clk);
        #1;
    endtask

    task automatic write(input int idx, input logic [7:0] k, input logic [31:0] d);
        idle(); wr_en = 1; wr_idx = 2'(idx); wr_key = k; wr_data = d;
        step();
    endtask

    task automatic lookup(input logic [7:0] k);
        idle(); req_valid = 1; req_key = k;
        step();
        idle();
    endtask

    initial begin
        idle();
        default_out = 32'hCAFE0000;
        rst_n = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 64'(resp_valid0), 64'd0);
        chk("rst_data", 64'(resp_data0), 64'd0);
        chk("rst_hit", 64'(resp_hit1), 64'd0);
        chk("rst_idx", 64'(resp_idx0), 64'd0);
        rst_n = 1;

        // Basic hit
        write(0, 8'h12, 32'hDEADBEEF);
        lookup(8'h12);
        chk("t1_valid", 64'(resp_valid0), 64'd1);
        chk("t1_data", 64'(resp_data0), 64'hDEADBEEF);
        chk("t1_hit", 64'(resp_hit0), 64'd1);
        chk("t1_idx", 64'(resp_idx0), 64'd0);
        step();

        // Miss on empty table, default vs zero
        idle(); clr = 1; step();
        lookup(8'h55);
        chk("t2_hit", 64'(resp_hit0), 64'd0);
        chk("t2_idx", 64'(resp_idx1), 64'd0);
        chk("t2_data0", 64'(resp_data0), 64'd0);
        chk("t2_data1", 64'(resp_data1), 64'hCAFE0000);

        // Duplicate keys resolve to lowest index
        write(2, 8'h07, 32'h2);
        write(1, 8'h07, 32'h1);
        lookup(8'h07);
        chk("t3_idx", 64'(resp_idx0), 64'd1);
        chk("t3_data", 64'(resp_data0), 64'h1);

        // Back-pressure holds response and blocks new request
        write(0, 8'h12, 32'hDEADBEEF);
        lookup(8'h07);
        for (int c = 0; c < 3; c++) begin
            idle(); resp_ready = 0; req_valid = 1; req_key = 8'h12;
            step();
            chk("t4_hold_data", 64'(resp_data0), 64'h1);
            chk("t4_req_ready", 64'(req_ready0), 64'd0);
        end
        idle(); req_valid = 1; req_key = 8'h12; step();
        chk("t4_new_data", 64'(resp_data0), 64'hDEADBEEF);
        chk("t4_new_idx", 64'(resp_idx0), 64'd0);
        idle(); step();

        // Same-cycle write and lookup
        idle(); wr_en = 1; wr_idx = 2'd3; wr_key = 8'h33; wr_data = 32'h99;
        req_valid = 1; req_key = 8'h33;
        step();
`ifdef MUX_KEY_TABLE_BYPASS_EN
        chk("t5_hit", 64'(resp_hit0), 64'd1);
        chk("t5_idx", 64'(resp_idx0), 64'd3);
        chk("t5_data", 64'(resp_data0), 64'h99);
`else
        chk("t5_hit", 64'(resp_hit0), 64'd0);
        chk("t5_data", 64'(resp_data0), 64'd0);
`endif
        idle(); clr = 1; wr_en = 1; wr_idx = 2'd3; wr_key = 8'h44; wr_data = 32'h5;
        step();
        lookup(8'h44);
        chk("t5_clr_miss", 64'(resp_hit0), 64'd0);

        // Async reset while a response is held
        write(1, 8'h07, 32'h1);
        idle(); resp_ready = 0; req_valid = 1; req_key = 8'h07; step();
        idle(); resp_ready = 0;
        #2 rst_n = 0;
        #1;
        chk("t6_async_valid", 64'(resp_valid0), 64'd0);
        model_reset();
        @(posedge clk);
        #1 rst_n = 1;
        idle();
        lookup(8'h07);
        chk("t6_after_miss", 64'(resp_hit0), 64'd0);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            clr         = ($urandom_range(0, 99) < 3);
            wr_en       = ($urandom_range(0, 99) < 30);
            wr_idx      = 2'($urandom_range(0, 3));
            wr_key      = 8'($urandom_range(0, 7));
            wr_data     = $urandom;
            default_out = $urandom;
            req_valid   = ($urandom_range(0, 99) < 60);
            req_key     = 8'($urandom_range(0, 7));
            resp_ready  = ($urandom_range(0, 99) < 70);
            step();
        end
        idle();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mux_key_table.md
Name: mux_key_table

Overview:
Programmable, registered key→data lookup table, the sequential successor of the combinational key-select mux.
- Holds NR_KEY writable (valid, key, data) entries.
- Accepts lookup requests over a valid/ready handshake and returns data, hit status and matching index one cycle later through a registered, back-pressurable response port.
- Used in the NPC for decode/CSR/MMIO-address tables that must be reprogrammed at run time.

Parameters:
NR_KEY, 4, number of table entries (≥2)
KEY_LEN, 8, key width in bits
DATA_LEN, 32, data width in bits
HAS_DEFAULT, 0, 1: miss returns default_out; 0: miss returns all-zero data
IDX_W, $clog2(NR_KEY), entry index width (derived; do not override)

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
clr  in  1  synchronous invalidate of all entries
wr_en  in  1  write entry this cycle
wr_idx  in  IDX_W  entry index to write
wr_key  in  KEY_LEN  key written
wr_data  in  DATA_LEN  data written
default_out  in  DATA_LEN  miss value when HAS_DEFAULT=1
req_valid  in  1  lookup request valid
req_ready  out  1  table can accept request
req_key  in  KEY_LEN  lookup key
resp_valid  out  1  response valid
resp_ready  in  1  consumer accepts response
resp_data  out  DATA_LEN  looked-up data
resp_hit  out  1  key matched a valid entry
resp_idx  out  IDX_W  matching entry index (0 on miss)

Behaviour:
- Reset (rst_n low, asynchronous):
  - all entry valid bits 0; entry key/data are don't-care.
  - resp_valid=0; resp_data=0; resp_hit=0; resp_idx=0.
- Handshake:
  - req_ready = !resp_valid || resp_ready (combinational; single response register, no skid).
  - Request accepted when req_valid && req_ready.
  - Response available the next cycle (latency 1).
  - Response fields are held stable while resp_valid && !resp_ready.
  - resp_valid clears when the response is consumed and no new request is accepted in the same cycle.
  - Back-to-back accepted requests give one response per cycle when resp_ready is held high.
- Match:
  - Entry i matches when valid[i] && key[i]==req_key.
  - Multiple matches resolve to the lowest index (priority, not OR-merge).
  - Matched data comes from that entry only.
- Miss:
  - resp_hit=0, resp_idx=0.
  - resp_data = default_out (sampled at acceptance) if HAS_DEFAULT, else 0.
- Write:
  - wr_en sets key[wr_idx], data[wr_idx] and valid[wr_idx]=1 at the clock edge.
  - wr_idx ≥ NR_KEY (non-power-of-2 NR_KEY) is ignored.
- clr:
  - Clears all valid bits at the edge.
  - clr together with wr_en: clr wins, the written entry ends invalid.
- Simultaneous lookup and write/clr in the same cycle: the lookup sees the pre-edge table contents (read-before-write), unless the optional feature below is enabled.
- Writes and clr are independent of handshake state; a held response is never modified by later writes.
- No internal state machine beyond resp_valid (states IDLE / HOLD).

Optional Feature:
Macro MUX_KEY_TABLE_BYPASS_EN.
- Defined: a lookup accepted in the same cycle as wr_en forwards the in-flight write.
  - If wr_key==req_key and no lower-indexed existing valid entry matches, the response returns wr_data and resp_idx=wr_idx with resp_hit=1.
  - A write overwriting the matching entry with a different key makes that entry miss.
  - clr in the same cycle forces a miss.
- Undefined: strict read-before-write as in Behaviour.

Decomposition:
- Package mux_key_pkg holds:
  - the resp status localparams (ST_HIT, ST_MISS),
  - a clog2-safe index-width function (returns 1 for NR_KEY≤2).
- One sub-module, mux_key_prio_enc: a combinational priority encoder, NR_KEY match vector → (any, lowest index). It is the only natural split.

Test Plan:
- Reset, write idx0 key 0x12 data 0xDEADBEEF, lookup 0x12 -> next cycle resp_valid=1, data 0xDEADBEEF, hit=1, idx=0.
- HAS_DEFAULT=1, default_out 0xCAFE0000, lookup 0x55 on empty table -> hit=0, idx=0, data 0xCAFE0000; HAS_DEFAULT=0 -> data 0.
- Write key 0x07 to idx2 (data 0x2) and idx1 (data 0x1), lookup 0x07 -> idx=1, data 0x1.
- Hold resp_ready=0 for 3 cycles after a hit -> response stable, req_ready=0, new request not accepted; release -> accepted that cycle, next response one cycle later.
- Same-cycle write key 0x33 data 0x99 to idx3 plus lookup 0x33 -> miss without macro, hit idx3 data 0x99 with MUX_KEY_TABLE_BYPASS_EN. Then clr+wr_en same cycle -> subsequent lookup misses.
- Assert rst_n low while resp_valid=1 and resp_ready=0 -> resp_valid drops immediately without a clock; after release, previously written keys miss.
